// File: rtl/me_best_mv_tracker.sv
// Integer-pel ME result stage: tracks the minimum SAD over a serpentine-scanned search window
// and hands the best motion vector to mode decision. Optional zero-vector credit: ME_ZERO_MV_BIAS_EN.
module me_best_mv_tracker #(
    parameter int MACRO_DIM  = 16,
    parameter int SEARCH_DIM = 32,
    parameter int SAD_W      = 16,
    parameter int ZERO_BIAS  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             readyi,
    input  logic             sad_valid,
    input  logic [SAD_W-1:0] sad,
    output logic             valido,
    input  logic             readyo,
    output logic [5:0]       mv_x,
    output logic [5:0]       mv_y,
    output logic [SAD_W-1:0] min_sad,
    output logic             err
);
    localparam int NPOS  = SEARCH_DIM - MACRO_DIM + 1;
    localparam int CTR   = (SEARCH_DIM - MACRO_DIM) / 2;
    localparam int NCAND = NPOS * NPOS;
    localparam int PW    = $clog2(NPOS + 1);
    localparam int KW    = $clog2(NCAND);
    localparam logic [SAD_W-1:0] BIAS = SAD_W'(ZERO_BIAS);
`ifdef ME_ZERO_MV_BIAS_EN
    localparam bit BIAS_EN = 1'b1;
`else
    localparam bit BIAS_EN = 1'b0;
`endif

    typedef enum logic [1:0] {S_IDLE, S_TRACK, S_DONE} state_t;

    state_t           r_state;
    logic [PW-1:0]    r_x, r_y, r_best_x, r_best_y;
    logic             r_dir_up;
    logic [KW-1:0]    r_k;
    logic [SAD_W-1:0] r_best_sad, r_min_sad;
    logic [5:0]       r_mv_x, r_mv_y;
    logic             r_readyi, r_valido, r_err;

    logic             w_is_ctr, w_hit, w_last;
    logic [SAD_W-1:0] w_sad_sat, w_cmp, w_best_sad_nxt;
    logic [PW-1:0]    w_best_x_nxt, w_best_y_nxt;

    assign w_is_ctr       = (r_x == PW'(CTR)) && (r_y == PW'(CTR));
    assign w_sad_sat      = (sad > BIAS) ? (sad - BIAS) : '0;
    assign w_cmp          = (BIAS_EN && w_is_ctr) ? w_sad_sat : sad;
    assign w_hit          = w_cmp < r_best_sad;
    assign w_best_sad_nxt = w_hit ? w_cmp : r_best_sad;
    assign w_best_x_nxt   = w_hit ? r_x : r_best_x;
    assign w_best_y_nxt   = w_hit ? r_y : r_best_y;
    assign w_last         = (r_k == KW'(NCAND - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_x        <= '0;
            r_y        <= '0;
            r_dir_up   <= 1'b0;
            r_k        <= '0;
            r_best_x   <= '0;
            r_best_y   <= '0;
            r_best_sad <= '0;
            r_min_sad  <= '0;
            r_mv_x     <= '0;
            r_mv_y     <= '0;
            r_readyi   <= 1'b1;
            r_valido   <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state    <= S_TRACK;
                        r_readyi   <= 1'b0;
                        r_best_sad <= '1;
                        r_best_x   <= '0;
                        r_best_y   <= '0;
                        r_x        <= '0;
                        r_y        <= '0;
                        r_dir_up   <= 1'b0;
                        r_k        <= '0;
                        r_err      <= 1'b0;
                    end else if (sad_valid) begin
                        r_err <= 1'b1;
                    end
                end
                S_TRACK: begin
                    if (sad_valid) begin
                        r_best_sad <= w_best_sad_nxt;
                        r_best_x   <= w_best_x_nxt;
                        r_best_y   <= w_best_y_nxt;
                        // serpentine: columns alternate down/up, turn at the window edge
                        if (!r_dir_up) begin
                            if (r_y == PW'(NPOS - 1)) begin
                                r_x      <= r_x + 1'b1;
                                r_dir_up <= 1'b1;
                            end else begin
                                r_y <= r_y + 1'b1;
                            end
                        end else begin
                            if (r_y == '0) begin
                                r_x      <= r_x + 1'b1;
                                r_dir_up <= 1'b0;
                            end else begin
                                r_y <= r_y - 1'b1;
                            end
                        end
                        if (w_last) begin
                            r_state   <= S_DONE;
                            r_valido  <= 1'b1;
                            r_mv_x    <= 6'(w_best_x_nxt) - 6'(CTR);
                            r_mv_y    <= 6'(w_best_y_nxt) - 6'(CTR);
                            r_min_sad <= w_best_sad_nxt;
                        end else begin
                            r_k <= r_k + 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    if (sad_valid) r_err <= 1'b1;
                    if (readyo) begin
                        r_state  <= S_IDLE;
                        r_valido <= 1'b0;
                        r_readyi <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign readyi  = r_readyi;
    assign valido  = r_valido;
    assign mv_x    = r_mv_x;
    assign mv_y    = r_mv_y;
    assign min_sad = r_min_sad;
    assign err     = r_err;
endmodule
